// File: rtl/move_applier.sv
// -----------------------------------------------------------------------------
// move_applier
//
// Sequential board-state writer. Holds the 12 piece bitboards and applies one
// move per accepted request, updating the boards in place. It checks that the
// mover belongs to the side to move, handles captures, pawn promotion and
// castling rook relocation, and toggles the side to move.
//
// Ports
//   clk                        system clock, all state changes on rising edge
//   rst                        synchronous, active-high reset (start position)
//   move_valid / move_ready    move request handshake (see below)
//   from_sq, to_sq             squares, index = 8*rank + file (a1=0, h8=63)
//   promo                      promotion piece: 0 N, 1 B, 2 R, 3 Q
//   piece_bitboards_flattened  board k at [64*k +: 64];
//                              k=0..5 black P,N,B,R,Q,K; k=6..11 white same
//   white_to_move              1 = white's turn
//   done                       one-cycle pulse when a move finishes
//   error                      one-cycle pulse with done when move was rejected
//   state_dbg                  current FSM state, for observation only
//
// Handshake: a move is taken on a rising edge where move_valid & move_ready
// are both high. move_ready is high only in IDLE, so from_sq, to_sq, promo and
// move_valid are ignored while a move is in flight; the request fields are
// latched at acceptance and never re-read.
//
// Cycle plan (T = acceptance cycle): SCAN T+1..T+12, APPLY T+13, then DONE at
// T+14 for a normal or rejected move, or CASTLE at T+14 and DONE at T+15.
// -----------------------------------------------------------------------------
module move_applier (
  input  logic         clk,
  input  logic         rst,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [5:0]   from_sq,
  input  logic [5:0]   to_sq,
  input  logic [1:0]   promo,
  output logic [767:0] piece_bitboards_flattened,
  output logic         white_to_move,
  output logic         done,
  output logic         error,
  output logic [2:0]   state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_CASTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Board indices used by name in the move logic.
  localparam logic [3:0] B_PAWN   = 4'd0;
  localparam logic [3:0] B_KING   = 4'd5;
  localparam logic [3:0] W_PAWN   = 4'd6;
  localparam logic [3:0] W_KING   = 4'd11;
  localparam logic [3:0] B_ROOK   = 4'd3;
  localparam logic [3:0] W_ROOK   = 4'd9;

  logic [2:0]  state;
  logic [3:0]  scan_idx;
  logic [5:0]  from_r;
  logic [5:0]  to_r;
  logic [1:0]  promo_r;
  logic [3:0]  mover;
  logic        has_mover;
  logic [3:0]  victim;
  logic        has_victim;
  logic        reject_r;
  logic [63:0] boards [0:11];

  // ---------------------------------------------------------------------------
  // APPLY-stage decode, all from latched request and scan results.
  // ---------------------------------------------------------------------------
  logic        mover_white;
  logic        victim_white;
  logic        reject;
  logic        promote;
  logic [3:0]  dest_board;
  logic [2:0]  file_diff;
  logic        is_castle;

  always_comb begin
    mover_white  = (mover >= W_PAWN);
    victim_white = (victim >= W_PAWN);

    reject = 1'b0;
    if (!has_mover)                                 reject = 1'b1;
    if (mover_white != white_to_move)               reject = 1'b1;
    if (from_r == to_r)                             reject = 1'b1;
    if (has_victim && (victim_white == mover_white)) reject = 1'b1;

    // A pawn reaching its last rank lands on the promoted piece's board,
    // which sits 1+promo boards above that colour's pawn board.
    promote    = 1'b0;
    dest_board = mover;
    if (mover == W_PAWN && to_r[5:3] == 3'd7) begin
      promote    = 1'b1;
      dest_board = W_PAWN + 4'd1 + {2'b00, promo_r};
    end
    if (mover == B_PAWN && to_r[5:3] == 3'd0) begin
      promote    = 1'b1;
      dest_board = B_PAWN + 4'd1 + {2'b00, promo_r};
    end

    file_diff = (from_r[2:0] > to_r[2:0]) ? (from_r[2:0] - to_r[2:0])
                                          : (to_r[2:0] - from_r[2:0]);
    is_castle = ((mover == B_KING) || (mover == W_KING)) && (file_diff == 3'd2);
  end

  // ---------------------------------------------------------------------------
  // CASTLE-stage decode: rook squares on the king's rank.
  // ---------------------------------------------------------------------------
  logic [3:0] rook_board;
  logic [5:0] rook_from;
  logic [5:0] rook_to;

  always_comb begin
    rook_board = (mover == W_KING) ? W_ROOK : B_ROOK;
    if (to_r[2:0] == 3'd6) begin
      rook_from = {from_r[5:3], 3'd7};
      rook_to   = {from_r[5:3], 3'd5};
    end else begin
      rook_from = {from_r[5:3], 3'd0};
      rook_to   = {from_r[5:3], 3'd3};
    end
  end

  // ---------------------------------------------------------------------------
  // Main FSM and board storage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      scan_idx      <= 4'd0;
      from_r        <= 6'd0;
      to_r          <= 6'd0;
      promo_r       <= 2'd0;
      mover         <= 4'd0;
      has_mover     <= 1'b0;
      victim        <= 4'd0;
      has_victim    <= 1'b0;
      reject_r      <= 1'b0;
      white_to_move <= 1'b1;
      boards[0]     <= 64'h00FF_0000_0000_0000;
      boards[1]     <= 64'h4200_0000_0000_0000;
      boards[2]     <= 64'h2400_0000_0000_0000;
      boards[3]     <= 64'h8100_0000_0000_0000;
      boards[4]     <= 64'h0800_0000_0000_0000;
      boards[5]     <= 64'h1000_0000_0000_0000;
      boards[6]     <= 64'h0000_0000_0000_FF00;
      boards[7]     <= 64'h0000_0000_0000_0042;
      boards[8]     <= 64'h0000_0000_0000_0024;
      boards[9]     <= 64'h0000_0000_0000_0081;
      boards[10]    <= 64'h0000_0000_0000_0008;
      boards[11]    <= 64'h0000_0000_0000_0010;
    end else begin
      case (state)
        S_IDLE: begin
          if (move_valid) begin
            from_r     <= from_sq;
            to_r       <= to_sq;
            promo_r    <= promo;
            scan_idx   <= 4'd0;
            has_mover  <= 1'b0;
            has_victim <= 1'b0;
            reject_r   <= 1'b0;
            state      <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (boards[scan_idx][from_r]) begin
            mover     <= scan_idx;
            has_mover <= 1'b1;
          end
          if (boards[scan_idx][to_r]) begin
            victim     <= scan_idx;
            has_victim <= 1'b1;
          end
          if (scan_idx == 4'd11) begin
            state <= S_APPLY;
          end else begin
            scan_idx <= scan_idx + 4'd1;
          end
        end

        S_APPLY: begin
          if (reject) begin
            reject_r <= 1'b1;
            state    <= S_DONE;
          end else begin
            // Later non-blocking writes win: clear the target square
            // everywhere (capture), clear the origin, then place the piece.
            for (int k = 0; k < 12; k++) begin
              boards[k][to_r] <= 1'b0;
            end
            boards[mover][from_r]   <= 1'b0;
            boards[dest_board][to_r] <= 1'b1;
            if (is_castle && !promote) begin
              state <= S_CASTLE;
            end else begin
              white_to_move <= ~white_to_move;
              state         <= S_DONE;
            end
          end
        end

        S_CASTLE: begin
          // A missing rook leaves the board alone; the upstream checker owns
          // castling legality.
          if (boards[rook_board][rook_from]) begin
            boards[rook_board][rook_from] <= 1'b0;
            boards[rook_board][rook_to]   <= 1'b1;
          end
          white_to_move <= ~white_to_move;
          state         <= S_DONE;
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign move_ready = (state == S_IDLE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_DONE) && reject_r;
  assign state_dbg  = state;

  for (genvar g = 0; g < 12; g++) begin : g_flat
    assign piece_bitboards_flattened[64*g +: 64] = boards[g];
  end

endmodule

// File: tb/tb_move_applier.sv
// -----------------------------------------------------------------------------
// tb_move_applier: directed self-checking bench for move_applier.
// Each scenario task drives moves and compares the DUT against hand-computed
// expected boards held in exp_b.
// -----------------------------------------------------------------------------
module tb_move_applier;

  logic         clk;
  logic         rst;
  logic         move_valid;
  logic         move_ready;
  logic [5:0]   from_sq;
  logic [5:0]   to_sq;
  logic [1:0]   promo;
  logic [767:0] piece_bitboards_flattened;
  logic         white_to_move;
  logic         done;
  logic         error;
  logic [2:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_b [0:11];

  move_applier dut (
    .clk                       (clk),
    .rst                       (rst),
    .move_valid                (move_valid),
    .move_ready                (move_ready),
    .from_sq                   (from_sq),
    .to_sq                     (to_sq),
    .promo                     (promo),
    .piece_bitboards_flattened (piece_bitboards_flattened),
    .white_to_move             (white_to_move),
    .done                      (done),
    .error                     (error),
    .state_dbg                 (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_start_model();
    exp_b[0]  = 64'h00FF_0000_0000_0000;
    exp_b[1]  = 64'h4200_0000_0000_0000;
    exp_b[2]  = 64'h2400_0000_0000_0000;
    exp_b[3]  = 64'h8100_0000_0000_0000;
    exp_b[4]  = 64'h0800_0000_0000_0000;
    exp_b[5]  = 64'h1000_0000_0000_0000;
    exp_b[6]  = 64'h0000_0000_0000_FF00;
    exp_b[7]  = 64'h0000_0000_0000_0042;
    exp_b[8]  = 64'h0000_0000_0000_0024;
    exp_b[9]  = 64'h0000_0000_0000_0081;
    exp_b[10] = 64'h0000_0000_0000_0008;
    exp_b[11] = 64'h0000_0000_0000_0010;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_start_model();
  endtask

  // Driver: present one move, return the cycle offset of done (-1 if none
  // within the budget), the error flag seen with done and move_ready at T+1.
  task automatic send_move(input logic [5:0] f, input logic [5:0] t,
                           input logic [1:0] p, output int lat,
                           output logic err, output logic rdy1);
    @(negedge clk);
    from_sq    = f;
    to_sq      = t;
    promo      = p;
    move_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scribble the request bus while busy; the DUT must ignore it.
    move_valid = 1'b1;
    from_sq    = 6'($urandom_range(0, 63));
    to_sq      = 6'($urandom_range(0, 63));
    promo      = 2'($urandom_range(0, 3));
    lat  = -1;
    err  = 1'b0;
    rdy1 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) rdy1 = move_ready;
      if (done) begin
        lat = n;
        err = error;
        break;
      end
    end
    move_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (move_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || white_to_move !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b error=%b wtm=%b, want 1 0 0 1",
               move_ready, done, error, white_to_move);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (piece_bitboards_flattened[64*k +: 64] !== exp_b[k]) begin
        errors++;
        $display("FAIL reset_board%0d: got %h want %h", k, piece_bitboards_flattened[64*k +: 64], exp_b[k]);
      end
    end
  endtask

  task automatic test_pawn_push();
    int lat; logic err; logic rdy1;
    do_reset();
    send_move(6'd12, 6'd28, 2'd0, lat, err, rdy1);
    checks++;
    if (lat != 14 || err !== 1'b0) begin
      errors++;
      $display("FAIL push_timing: done at T+%0d err=%b, want T+14 err=0", lat, err);
    end
    checks++;
    if (rdy1 !== 1'b0) begin
      errors++;
      $display("FAIL push_ready_busy: move_ready=%b at T+1, want 0", rdy1);
    end
    checks++;
    if (piece_bitboards_flattened[64*6 +: 64] !== 64'h0000_0000_1000_EF00 || white_to_move !== 1'b0) begin
      errors++;
      $display("FAIL push_board: board6=%h wtm=%b, want 000000001000ef00 wtm=0",
               piece_bitboards_flattened[64*6 +: 64], white_to_move);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || move_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_after_done: done=%b ready=%b, want 0 1", done, move_ready);
    end
  endtask

  // Rejected moves: empty origin, wrong side, null move, own-piece capture.
  task automatic test_rejects();
    int lat; logic err; logic rdy1;
    logic [5:0] rf [0:3];
    logic [5:0] rt [0:3];
    rf[0] = 6'd20; rt[0] = 6'd28;
    rf[1] = 6'd52; rt[1] = 6'd36;
    rf[2] = 6'd12; rt[2] = 6'd12;
    rf[3] = 6'd1;  rt[3] = 6'd11;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_move(rf[i], rt[i], 2'd0, lat, err, rdy1);
      checks++;
      if (lat != 14 || err !== 1'b1) begin
        errors++;
        $display("FAIL reject%0d: done at T+%0d err=%b, want T+14 err=1", i, lat, err);
      end
      checks++;
      if (white_to_move !== 1'b1) begin
        errors++;
        $display("FAIL reject%0d_wtm: got %b want 1", i, white_to_move);
      end
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (piece_bitboards_flattened[64*k +: 64] !== exp_b[k]) begin
          errors++;
          $display("FAIL reject%0d_board%0d: got %h want %h", i, k, piece_bitboards_flattened[64*k +: 64], exp_b[k]);
        end
      end
    end
  endtask

  task automatic test_capture();
    int lat; logic err; logic rdy1;
    do_reset();
    send_move(6'd12, 6'd28, 2'd0, lat, err, rdy1);
    send_move(6'd51, 6'd35, 2'd0, lat, err, rdy1);
    send_move(6'd28, 6'd35, 2'd0, lat, err, rdy1);
    checks++;
    if (lat != 14 || err !== 1'b0) begin
      errors++;
      $display("FAIL capture_timing: done at T+%0d err=%b, want T+14 err=0", lat, err);
    end
    exp_b[0] = 64'h00F7_0000_0000_0000;
    exp_b[6] = 64'h0000_0008_0000_EF00;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (piece_bitboards_flattened[64*k +: 64] !== exp_b[k]) begin
        errors++;
        $display("FAIL capture_board%0d: got %h want %h", k, piece_bitboards_flattened[64*k +: 64], exp_b[k]);
      end
    end
    checks++;
    if (white_to_move !== 1'b0) begin
      errors++;
      $display("FAIL capture_wtm: got %b want 0", white_to_move);
    end
  endtask

  task automatic test_castle();
    int lat; logic err; logic rdy1;
    do_reset();
    send_move(6'd6,  6'd21, 2'd0, lat, err, rdy1);
    send_move(6'd48, 6'd40, 2'd0, lat, err, rdy1);
    send_move(6'd5,  6'd26, 2'd0, lat, err, rdy1);
    send_move(6'd49, 6'd41, 2'd0, lat, err, rdy1);
    send_move(6'd4,  6'd6,  2'd0, lat, err, rdy1);
    checks++;
    if (lat != 15 || err !== 1'b0) begin
      errors++;
      $display("FAIL castle_timing: done at T+%0d err=%b, want T+15 err=0", lat, err);
    end
    exp_b[0]  = 64'h00FC_0300_0000_0000;
    exp_b[7]  = 64'h0000_0000_0020_0002;
    exp_b[8]  = 64'h0000_0000_0400_0004;
    exp_b[9]  = 64'h0000_0000_0000_0021;
    exp_b[11] = 64'h0000_0000_0000_0040;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (piece_bitboards_flattened[64*k +: 64] !== exp_b[k]) begin
        errors++;
        $display("FAIL castle_board%0d: got %h want %h", k, piece_bitboards_flattened[64*k +: 64], exp_b[k]);
      end
    end
    checks++;
    if (white_to_move !== 1'b0) begin
      errors++;
      $display("FAIL castle_wtm: got %b want 0", white_to_move);
    end
  endtask

  task automatic test_promotion();
    int lat; logic err; logic rdy1;
    do_reset();
    send_move(6'd12, 6'd52, 2'd0, lat, err, rdy1);
    send_move(6'd48, 6'd40, 2'd0, lat, err, rdy1);
    send_move(6'd52, 6'd60, 2'd3, lat, err, rdy1);
    checks++;
    if (lat != 14 || err !== 1'b0) begin
      errors++;
      $display("FAIL promo_w_timing: done at T+%0d err=%b, want T+14 err=0", lat, err);
    end
    exp_b[0]  = 64'h00EE_0100_0000_0000;
    exp_b[5]  = 64'h0000_0000_0000_0000;
    exp_b[6]  = 64'h0000_0000_0000_EF00;
    exp_b[10] = 64'h1000_0000_0000_0008;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (piece_bitboards_flattened[64*k +: 64] !== exp_b[k]) begin
        errors++;
        $display("FAIL promo_w_board%0d: got %h want %h", k, piece_bitboards_flattened[64*k +: 64], exp_b[k]);
      end
    end
    // Black pawn promotes to a bishop on a1, capturing the white rook.
    send_move(6'd40, 6'd0, 2'd1, lat, err, rdy1);
    exp_b[0] = 64'h00EE_0000_0000_0000;
    exp_b[2] = 64'h2400_0000_0000_0001;
    exp_b[9] = 64'h0000_0000_0000_0080;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (piece_bitboards_flattened[64*k +: 64] !== exp_b[k]) begin
        errors++;
        $display("FAIL promo_b_board%0d: got %h want %h", k, piece_bitboards_flattened[64*k +: 64], exp_b[k]);
      end
    end
    checks++;
    if (white_to_move !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL promo_b_wtm: wtm=%b err=%b, want 1 0", white_to_move, err);
    end
  endtask

  task automatic test_reset_mid_move();
    int done_seen;
    do_reset();
    @(negedge clk);
    from_sq = 6'd12; to_sq = 6'd28; promo = 2'd0; move_valid = 1'b1;
    @(posedge clk);
    #1 move_valid = 1'b0;
    for (int n = 1; n <= 5; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (move_ready !== 1'b1 || done !== 1'b0 || white_to_move !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ctrl: ready=%b done=%b wtm=%b, want 1 0 1", move_ready, done, white_to_move);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (piece_bitboards_flattened[64*k +: 64] !== exp_b[k]) begin
        errors++;
        $display("FAIL midrst_board%0d: got %h want %h", k, piece_bitboards_flattened[64*k +: 64], exp_b[k]);
      end
    end
    done_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL midrst_no_done: saw %0d done pulses, want 0", done_seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    move_valid = 1'b0;
    from_sq = 6'd0;
    to_sq = 6'd0;
    promo = 2'd0;
    set_start_model();
    test_reset();
    test_pawn_push();
    test_rejects();
    test_capture();
    test_castle();
    test_promotion();
    test_reset_mid_move();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
